// File: rtl/accumulator_unit.sv
// Accumulator register with load/add/sub/shift ops, flags, and an optional
// multi-cycle shift-add multiply behind a go/busy/done handshake.
module accumulator_unit #(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] Input,
  input  logic [2:0]       op,
  input  logic             go,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Output,
  output logic             Aeq0,
  output logic             Apos,
  output logic             Carry,
  output logic             Ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000, OP_LDD = 3'b001, OP_LDI = 3'b010, OP_ADD = 3'b011,
    OP_SUB = 3'b100, OP_SHL = 3'b101, OP_SAR = 3'b110, OP_MUL = 3'b111
  } op_t;

  typedef struct packed {
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;
  } mul_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  mul_t               mul_q, mul_d;

  // Shared adder: SUB is A + ~data + 1, so carry-out of 1 means no borrow.
  logic               is_sub;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_step;

  assign is_sub    = (op == OP_SUB);
  assign add_b     = is_sub ? ~data : data;
  assign sum       = {1'b0, a_q} + {1'b0, add_b} + {{WIDTH{1'b0}}, is_sub};
  assign prod_step = mul_q.prod + (mul_q.mplier[0] ? mul_q.mcand : '0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    mul_d   = mul_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          done_d = 1'b1;
          unique case (op_t'(op))
            OP_NOP: ;
            OP_LDD: begin a_d = data;  carry_d = 1'b0; ovf_d = 1'b0; end
            OP_LDI: begin a_d = Input; carry_d = 1'b0; ovf_d = 1'b0; end
            OP_ADD, OP_SUB: begin
              a_d     = sum[WIDTH-1:0];
              carry_d = sum[WIDTH];
              ovf_d   = (a_q[WIDTH-1] == add_b[WIDTH-1]) &&
                        (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SHL: begin
              a_d     = {a_q[WIDTH-2:0], 1'b0};
              carry_d = a_q[WIDTH-1];
              ovf_d   = a_q[WIDTH-1] ^ a_q[WIDTH-2];
            end
            OP_SAR: begin
              a_d     = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
              carry_d = a_q[0];
              ovf_d   = 1'b0;
            end
            OP_MUL: begin
              if (MUL_EN != 0) begin
                done_d       = 1'b0;
                state_d      = MUL;
                mul_d.mcand  = {{WIDTH{1'b0}}, a_q};
                mul_d.mplier = data;
                mul_d.prod   = '0;
                mul_d.cnt    = CW'(WIDTH);
              end
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        mul_d.prod   = prod_step;
        mul_d.mcand  = mul_q.mcand << 1;
        mul_d.mplier = mul_q.mplier >> 1;
        mul_d.cnt    = mul_q.cnt - 1'b1;
        // Last iteration folds straight into A so done lands at go + WIDTH.
        if (mul_q.cnt == CW'(1)) begin
          a_d     = prod_step[WIDTH-1:0];
          carry_d = |prod_step[2*WIDTH-1:WIDTH];
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      mul_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      mul_q   <= mul_d;
    end
  end

  assign busy   = (state_q == MUL);
  assign done   = done_q;
  assign Output = a_q;
  assign Aeq0   = (a_q == '0);
  assign Apos   = ~a_q[WIDTH-1];
  assign Carry  = carry_q;
  assign Ovf    = ovf_q;

endmodule

// File: tb/tb_accumulator_unit.sv
// Directed bench for accumulator_unit: one MUL-enabled and one MUL-disabled
// instance share the same stimulus.
module tb_accumulator_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = '0, inp = '0;
  logic [2:0] op = '0;
  logic       go = 1'b0;

  logic       busy, done, aeq0, apos, carry, ovf;
  logic [7:0] a_out;
  logic       busy_n, done_n, aeq0_n, apos_n, carry_n, ovf_n;
  logic [7:0] a_out_n;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  accumulator_unit #(.WIDTH(8), .MUL_EN(1)) dut (
    .clk(clk), .reset(reset), .data(data), .Input(inp), .op(op), .go(go),
    .busy(busy), .done(done), .Output(a_out), .Aeq0(aeq0), .Apos(apos),
    .Carry(carry), .Ovf(ovf)
  );

  accumulator_unit #(.WIDTH(8), .MUL_EN(0)) dut_nomul (
    .clk(clk), .reset(reset), .data(data), .Input(inp), .op(op), .go(go),
    .busy(busy_n), .done(done_n), .Output(a_out_n), .Aeq0(aeq0_n), .Apos(apos_n),
    .Carry(carry_n), .Ovf(ovf_n)
  );

  // One accepted op: inputs set between edges, outputs sampled 1ns after edge.
  task automatic issue(input logic [2:0] o, input logic [7:0] d);
    op = o; data = d; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++;
    if ({a_out, aeq0, apos, busy, done, carry, ovf} !== {8'h00, 6'b110000}) begin
      fails++;
      $display("FAIL reset A=%h aeq0=%b apos=%b busy=%b done=%b c=%b v=%b",
               a_out, aeq0, apos, busy, done, carry, ovf);
    end
  endtask

  task automatic test_add_ovf;
    issue(3'b001, 8'h7F);
    tests++;
    if (a_out !== 8'h7F || done !== 1'b1) begin
      fails++; $display("FAIL ldd A=%h done=%b exp 7f/1", a_out, done);
    end
    issue(3'b011, 8'h01);
    tests++;
    if ({a_out, ovf, carry, apos, done} !== {8'h80, 4'b1001}) begin
      fails++;
      $display("FAIL add_ovf A=%h v=%b c=%b apos=%b done=%b exp 80/1/0/0/1",
               a_out, ovf, carry, apos, done);
    end
    issue(3'b001, 8'hFF);
    issue(3'b011, 8'h01);
    tests++;
    if ({a_out, carry, ovf, aeq0} !== {8'h00, 3'b101}) begin
      fails++; $display("FAIL add_wrap A=%h c=%b v=%b z=%b exp 00/1/0/1", a_out, carry, ovf, aeq0);
    end
  endtask

  task automatic test_sub;
    issue(3'b001, 8'h05);
    issue(3'b100, 8'h05);
    tests++;
    if ({a_out, aeq0, carry, ovf} !== {8'h00, 3'b110}) begin
      fails++; $display("FAIL sub_zero A=%h z=%b c=%b v=%b exp 00/1/1/0", a_out, aeq0, carry, ovf);
    end
    issue(3'b100, 8'h01);
    tests++;
    if ({a_out, carry, aeq0, apos} !== {8'hFF, 3'b000}) begin
      fails++; $display("FAIL sub_borrow A=%h c=%b z=%b p=%b exp ff/0/0/0", a_out, carry, aeq0, apos);
    end
    issue(3'b001, 8'h80);
    issue(3'b100, 8'h01);
    tests++;
    if ({a_out, carry, ovf} !== {8'h7F, 2'b11}) begin
      fails++; $display("FAIL sub_ovf A=%h c=%b v=%b exp 7f/1/1", a_out, carry, ovf);
    end
  endtask

  task automatic test_shift;
    issue(3'b001, 8'h81);
    issue(3'b110, 8'h00);
    tests++;
    if ({a_out, carry, ovf} !== {8'hC0, 2'b10}) begin
      fails++; $display("FAIL sar A=%h c=%b v=%b exp c0/1/0", a_out, carry, ovf);
    end
    issue(3'b001, 8'h81);
    issue(3'b101, 8'h00);
    tests++;
    if ({a_out, carry, ovf} !== {8'h02, 2'b11}) begin
      fails++; $display("FAIL shl A=%h c=%b v=%b exp 02/1/1", a_out, carry, ovf);
    end
  endtask

  task automatic test_ldi_nop;
    inp = 8'hA5;
    issue(3'b010, 8'h00);
    tests++;
    if ({a_out, carry, ovf} !== {8'hA5, 2'b00}) begin
      fails++; $display("FAIL ldi A=%h c=%b v=%b exp a5/0/0", a_out, carry, ovf);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL done_pulse done=%b exp 0", done);
    end
    issue(3'b000, 8'h33);
    tests++;
    if ({a_out, done} !== {8'hA5, 1'b1}) begin
      fails++; $display("FAIL nop A=%h done=%b exp a5/1", a_out, done);
    end
  endtask

  task automatic test_back_to_back;
    op = 3'b001; data = 8'h10; go = 1'b1;
    @(posedge clk); #1;
    op = 3'b011; data = 8'h05;
    @(posedge clk); #1;
    go = 1'b0;
    tests++;
    if ({a_out, done} !== {8'h15, 1'b1}) begin
      fails++; $display("FAIL back_to_back A=%h done=%b exp 15/1", a_out, done);
    end
  endtask

  task automatic test_mul;
    int n;
    logic held_ok;
    issue(3'b001, 8'd12);
    issue(3'b111, 8'd11);
    tests++;
    if ({busy, done} !== 2'b10) begin
      fails++; $display("FAIL mul_start busy=%b done=%b exp 1/0", busy, done);
    end
    // go+LDI held during the multiply must be ignored
    inp = 8'h55; op = 3'b010; go = 1'b1;
    held_ok = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin n = i; break; end
      if (a_out !== 8'd12 || busy !== 1'b1) held_ok = 1'b0;
    end
    go = 1'b0;
    tests++;
    if (n != 8) begin
      fails++; $display("FAIL mul_latency done after %0d edges exp 8", n);
    end
    tests++;
    if (!held_ok) begin
      fails++; $display("FAIL mul_hold A or busy changed during MUL, exp A=0c busy=1");
    end
    tests++;
    if ({a_out, carry, ovf, busy} !== {8'h84, 3'b000}) begin
      fails++; $display("FAIL mul_result A=%h c=%b v=%b busy=%b exp 84/0/0/0", a_out, carry, ovf, busy);
    end
    issue(3'b001, 8'h20);
    issue(3'b111, 8'h10);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin n = i; break; end
    end
    tests++;
    if (n != 8 || {a_out, carry, aeq0} !== {8'h00, 2'b11}) begin
      fails++; $display("FAIL mul_carry edges=%0d A=%h c=%b z=%b exp 8/00/1/1", n, a_out, carry, aeq0);
    end
  endtask

  task automatic test_reset_mid_mul;
    logic saw_done;
    issue(3'b001, 8'd7);
    issue(3'b111, 8'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++;
    if ({a_out, busy, done} !== {8'h00, 2'b00}) begin
      fails++; $display("FAIL reset_mid_mul A=%h busy=%b done=%b exp 00/0/0", a_out, busy, done);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    tests++;
    if (saw_done) begin
      fails++; $display("FAIL aborted_mul_done saw done/busy after abort, exp none");
    end
  endtask

  task automatic test_mul_disabled;
    issue(3'b001, 8'h33);
    issue(3'b111, 8'h02);
    tests++;
    if ({a_out_n, done_n, busy_n} !== {8'h33, 2'b10}) begin
      fails++; $display("FAIL mul_en0 A=%h done=%b busy=%b exp 33/1/0", a_out_n, done_n, busy_n);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    test_reset;
    test_add_ovf;
    test_sub;
    test_shift;
    test_ldi_nop;
    test_back_to_back;
    test_mul;
    test_reset_mid_mul;
    test_mul_disabled;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
